// File: rtl/ahb_mailbox_sender.sv
// AHB-Lite initiator that posts one message into a mailbox channel: polls the channel ctrl word
// until empty, writes the payload into mailbox RAM, then raises full/intr in the ctrl word.
module ahb_mailbox_sender #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] MBOX_BASE  = 32'h4000_0000,
   parameter int          CHANNEL    = 0,
   parameter logic [31:0] RAM_OFFSET = 32'h8000,
   parameter int          MAX_WORDS  = 8192,
   parameter int          POLL_GAP   = 16
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic                  hwrite,
   output logic [2:0]            hsize,
   output logic [2:0]            hburst,
   output logic [3:0]            hprot,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   input  logic [1:0]            hresp,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  msg_start,
   input  logic [7:0]            msg_id,
   input  logic [14:0]           msg_size,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [1:0]            TR_IDLE   = 2'b00;
   localparam logic [1:0]            TR_NONSEQ = 2'b10;
   localparam logic [1:0]            RESP_ERR  = 2'b01;
   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(MBOX_BASE + 32'(4 * CHANNEL));
   localparam logic [ADDR_WIDTH-1:0] RAM_BASE  = ADDR_WIDTH'(MBOX_BASE + RAM_OFFSET);
   localparam logic [14:0]           SIZE_MAX  = 15'(MAX_WORDS);
   localparam int                    GAP_W     = $clog2(POLL_GAP + 1);
   localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL_A,
      S_POLL_D,
      S_WAIT,
      S_DATA_A,
      S_DATA_D,
      S_CTRL_A,
      S_CTRL_D
   } state_t;

   state_t           state;
   logic [13:0]      idx;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       id_q;
   logic [14:0]      size_q;
   logic [31:0]      ctrl_word;
   logic             is_last;
   logic             bus_error;
   logic             unused_rdata;

   function automatic logic [ADDR_WIDTH-1:0] ram_addr(input logic [13:0] i);
      return RAM_BASE + ADDR_WIDTH'({i, 2'b00});
   endfunction

   assign hsize     = 3'b010;
   assign hburst    = 3'b000;
   assign hprot     = 4'b0011;
   assign ctrl_word = {2'b11, 7'b0, size_q, id_q};
   assign is_last   = ({1'b0, idx} == (size_q - 15'd1));
   assign bus_error = (hresp == RESP_ERR);
   // only the full flag of the polled ctrl word matters
   assign unused_rdata = ^hrdata;

   // the pop happens in the very cycle the slave accepts the payload address phase
   assign tx_ready = (state == S_DATA_A) && (htrans == TR_NONSEQ) && hready;

   // message descriptor is plain data: captured on an accepted start, never reset
   always_ff @(posedge hclk) begin
      if (state == S_IDLE && msg_start && msg_size <= SIZE_MAX) begin
         id_q   <= msg_id;
         size_q <= msg_size;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state   <= S_IDLE;
         htrans  <= TR_IDLE;
         haddr   <= '0;
         hwrite  <= 1'b0;
         hwdata  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         idx     <= '0;
         gap_cnt <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (msg_start) begin
                  if (msg_size > SIZE_MAX) begin
                     err <= 1'b1;
                  end else begin
                     busy   <= 1'b1;
                     htrans <= TR_NONSEQ;
                     haddr  <= CTRL_ADDR;
                     hwrite <= 1'b0;
                     state  <= S_POLL_A;
                  end
               end
            end

            S_POLL_A: begin
               if (hready) begin
                  htrans <= TR_IDLE;
                  haddr  <= '0;
                  state  <= S_POLL_D;
               end
            end

            S_POLL_D: begin
               if (hready) begin
                  if (bus_error) begin
                     busy  <= 1'b0;
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else if (hrdata[30]) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= S_WAIT;
                  end else if (size_q == 15'd0) begin
                     htrans <= TR_NONSEQ;
                     haddr  <= CTRL_ADDR;
                     hwrite <= 1'b1;
                     state  <= S_CTRL_A;
                  end else begin
                     idx   <= '0;
                     state <= S_DATA_A;
                     if (tx_valid) begin
                        htrans <= TR_NONSEQ;
                        haddr  <= ram_addr(14'd0);
                        hwrite <= 1'b1;
                     end
                  end
               end
            end

            S_WAIT: begin
               if (gap_cnt == '0) begin
                  htrans <= TR_NONSEQ;
                  haddr  <= CTRL_ADDR;
                  hwrite <= 1'b0;
                  state  <= S_POLL_A;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            // DATA_A covers both the stalled wait for tx_valid and the live address phase
            S_DATA_A: begin
               if (htrans == TR_NONSEQ) begin
                  if (hready) begin
                     hwdata <= tx_data;
                     htrans <= TR_IDLE;
                     haddr  <= '0;
                     hwrite <= 1'b0;
                     state  <= S_DATA_D;
                  end
               end else if (tx_valid) begin
                  htrans <= TR_NONSEQ;
                  haddr  <= ram_addr(idx);
                  hwrite <= 1'b1;
               end
            end

            S_DATA_D: begin
               if (hready) begin
                  if (bus_error) begin
                     busy  <= 1'b0;
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else if (is_last) begin
                     htrans <= TR_NONSEQ;
                     haddr  <= CTRL_ADDR;
                     hwrite <= 1'b1;
                     state  <= S_CTRL_A;
                  end else begin
                     idx   <= idx + 14'd1;
                     state <= S_DATA_A;
                     if (tx_valid) begin
                        htrans <= TR_NONSEQ;
                        haddr  <= ram_addr(idx + 14'd1);
                        hwrite <= 1'b1;
                     end
                  end
               end
            end

            S_CTRL_A: begin
               if (hready) begin
                  hwdata <= DATA_WIDTH'(ctrl_word);
                  htrans <= TR_IDLE;
                  haddr  <= '0;
                  hwrite <= 1'b0;
                  state  <= S_CTRL_D;
               end
            end

            S_CTRL_D: begin
               if (hready) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                  if (bus_error) begin
                     err <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end

            default: begin
               state  <= S_IDLE;
               htrans <= TR_IDLE;
               haddr  <= '0;
               hwrite <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
